// File: rtl/bus_pkg.sv
// Shared types for the multiplexed-bus responder.
// Cycle states, access direction and the window-hit helper.
package bus_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        WAIT,
        ACCESS
    } state_t;

    typedef enum logic {
        DIR_RD,
        DIR_WR
    } dir_t;

    function automatic logic addr_hit(
        input logic [15:0] a,
        input logic        io,
        input logic [15:0] base,
        input int unsigned aw
    );
        logic [16:0] diff;
        diff = {1'b0, a} - {1'b0, base};
        return !io && (a >= base) && (diff < (17'd1 << aw));
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Control/status half of the 8085-style bus.
// The master drives strobes and ALE; the responder returns READY, SEL and errors.
interface bus_responder_if;

    logic       ale;
    logic [7:0] addr_hi;
    logic       rd_n;
    logic       wr_n;
    logic       io_m;
    logic       ready;
    logic       sel;
    logic       bus_err;

    modport master (
        output ale, addr_hi, rd_n, wr_n, io_m,
        input  ready, sel, bus_err
    );

    modport slave (
        input  ale, addr_hi, rd_n, wr_n, io_m,
        output ready, sel, bus_err
    );

endinterface

// File: rtl/bus_responder_resp_mem.sv
// Byte RAM behind the responder.
// Synchronous write, registered read with one cycle of latency.
module resp_mem #(
    parameter int AW = 8
) (
    input  logic          phi1,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge phi1) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 8085-style multiplexed bus.
// Latches the address on ALE, decodes the window, inserts READY waits, serves RAM.
module bus_responder
    import bus_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h0100,
    parameter int          MEM_AW      = 8,
    parameter int          WAIT_STATES = 1
) (
    input  logic           phi1,
    input  logic           rst,
    bus_responder_if.slave bus,
    inout  wire  [7:0]     ad
);

    localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
        WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                r_state;
    dir_t                  r_dir;
    logic [15:0]           r_addr;
    logic                  r_sel;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_oe;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [7:0]            r_wdata;

    logic [15:0]           w_new_addr;
    logic                  w_new_hit;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_own;
    logic                  w_other;
    logic                  w_we;
    logic [MEM_AW-1:0]     w_off;
    logic [7:0]            w_rdata;

    assign w_new_addr = {bus.addr_hi, ad};
    assign w_new_hit  = addr_hit(w_new_addr, bus.io_m, BASE, MEM_AW);
    assign w_rd       = ~bus.rd_n;
    assign w_wr       = ~bus.wr_n;
    assign w_own      = (r_dir == DIR_WR) ? w_wr : w_rd;
    assign w_other    = (r_dir == DIR_WR) ? w_rd : w_wr;
    assign w_off      = MEM_AW'(r_addr - BASE);

    // Trailing-edge commit: only a clean strobe release in ACCESS writes.
    assign w_we = ~rst & ~bus.ale
                & (r_state == ACCESS) & (r_dir == DIR_WR)
                & ~w_rd & ~w_wr;

    resp_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .phi1    (phi1),
        .i_we    (w_we),
        .i_waddr (w_off),
        .i_wdata (r_wdata),
        .i_raddr (w_off),
        .o_rdata (w_rdata)
    );

    assign ad          = r_oe ? w_rdata : 8'bz;
    assign bus.ready   = r_ready;
    assign bus.sel     = r_sel;
    assign bus.bus_err = r_err;

    always_ff @(posedge phi1) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir   <= DIR_RD;
            r_addr  <= '0;
            r_sel   <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_oe    <= 1'b0;
            r_cnt   <= '0;
            r_wdata <= '0;
        end else begin
            r_err <= 1'b0;
            if (bus.ale) begin
                // New address phase; any cycle in flight is dropped.
                r_addr  <= w_new_addr;
                r_sel   <= w_new_hit;
                r_ready <= 1'b1;
                r_oe    <= 1'b0;
                r_state <= LATCHED;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LATCHED: begin
                        if (w_rd && w_wr) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else if (w_rd || w_wr) begin
                            if (!r_sel) begin
                                r_state <= IDLE;
                            end else begin
                                r_dir <= w_wr ? DIR_WR : DIR_RD;
                                if (w_wr) begin
                                    r_wdata <= ad;
                                end
                                if (WAIT_STATES > 0) begin
                                    r_cnt   <= WS_LOAD;
                                    r_ready <= 1'b0;
                                    r_state <= WAIT;
                                end else begin
                                    r_oe    <= w_rd;
                                    r_state <= ACCESS;
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (!w_own || w_other) begin
                            r_err   <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            if (r_dir == DIR_WR) begin
                                r_wdata <= ad;
                            end
                            if (r_cnt == '0) begin
                                r_ready <= 1'b1;
                                r_oe    <= (r_dir == DIR_RD);
                                r_state <= ACCESS;
                            end else begin
                                r_cnt <= r_cnt - WAIT_CNT_W'(1);
                            end
                        end
                    end
                    ACCESS: begin
                        if (w_other) begin
                            r_err   <= 1'b1;
                            r_oe    <= 1'b0;
                            r_state <= IDLE;
                        end else if (!w_own) begin
                            r_oe    <= 1'b0;
                            r_state <= IDLE;
                        end else if (r_dir == DIR_WR) begin
                            r_wdata <= ad;
                        end
                    end
                    default: begin
                        r_oe    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Randomized scoreboard bench for bus_responder.
// Stimulus tasks queue per-cycle expectations; a negedge monitor compares them.
module tb_bus_responder;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          AW    = 8;
    localparam int          DEPTH = 256;
    localparam int          WS    = 1;

    typedef struct {
        int         cyc;
        logic       rdy;
        logic       sel;
        logic       err;
        logic       drv;
        logic [7:0] dat;
        string      tag;
    } exp_t;

    logic       phi1 = 1'b0;
    logic       rst;
    logic       tb_oe;
    logic [7:0] tb_d;
    tri1  [7:0] ad;

    bus_responder_if bus ();

    assign ad = tb_oe ? tb_d : 8'bz;

    bus_responder #(
        .BASE        (BASE),
        .MEM_AW      (AW),
        .WAIT_STATES (WS)
    ) dut (
        .phi1 (phi1),
        .rst  (rst),
        .bus  (bus),
        .ad   (ad)
    );

    always #5 phi1 = ~phi1;

    int         cyc_cnt = 0;
    int         n_cmp   = 0;
    int         n_bad   = 0;
    exp_t       q[$];
    logic [7:0] mem_m [DEPTH];
    logic       sel_m;

    always @(posedge phi1) cyc_cnt <= cyc_cnt + 1;

    function automatic logic hit_m(input logic [15:0] a, input logic io);
        int d;
        d = int'(a) - int'(BASE);
        return !io && d >= 0 && d < DEPTH;
    endfunction

    always @(negedge phi1) begin
        exp_t       e;
        logic [7:0] want_ad;
        while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d missed at cycle %0d",
                     e.tag, e.cyc, cyc_cnt);
        end
        if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
            e = q.pop_front();
            want_ad = tb_oe ? tb_d : (e.drv ? e.dat : 8'hFF);
            n_cmp++;
            if ({bus.ready, bus.sel, bus.bus_err, ad} !==
                {e.rdy, e.sel, e.err, want_ad}) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: rdy/sel/err/ad got %b/%b/%b/%h want %b/%b/%b/%h",
                         e.tag, cyc_cnt, bus.ready, bus.sel, bus.bus_err, ad,
                         e.rdy, e.sel, e.err, want_ad);
            end
        end
    end

    task automatic drive(
        input logic r, input logic al, input logic [7:0] ahi,
        input logic oe, input logic [7:0] d,
        input logic rdn, input logic wrn, input logic io,
        input logic e_rdy, input logic e_err, input logic e_drv,
        input logic [7:0] e_dat, input string tag
    );
        exp_t e;
        @(posedge phi1);
        #1;
        rst         = r;
        bus.ale     = al;
        bus.addr_hi = ahi;
        tb_oe       = oe;
        tb_d        = d;
        bus.rd_n    = rdn;
        bus.wr_n    = wrn;
        bus.io_m    = io;
        e.cyc = cyc_cnt + 1;
        e.rdy = e_rdy;
        e.sel = sel_m;
        e.err = e_err;
        e.drv = e_drv;
        e.dat = e_dat;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, tag);
    endtask

    task automatic latch(input logic [15:0] a, input logic io, input string tag);
        sel_m = hit_m(a, io);
        drive(0, 1, a[15:8], 1, a[7:0], 1, 1, io, 1, 0, 0, 8'h00, tag);
    endtask

    task automatic rd_strobe(input logic [15:0] a, input logic io,
                             input int n, input string tag);
        logic       h;
        int         off;
        logic [7:0] dv;
        h   = hit_m(a, io);
        off = int'(a) - int'(BASE);
        dv  = 8'h00;
        if (h) dv = mem_m[off];
        for (int i = 0; i < n; i++)
            drive(0, 0, 8'h00, 0, 8'h00, 0, 1, io,
                  !h || i >= WS, 0, h && i >= WS, dv, tag);
        drive(0, 0, 8'h00, 0, 8'h00, 1, 1, io, 1, 0, 0, 8'h00, tag);
    endtask

    task automatic do_read(input logic [15:0] a, input logic io,
                           input int n, input string tag);
        latch(a, io, tag);
        rd_strobe(a, io, n, tag);
    endtask

    task automatic do_write(input logic [15:0] a, input logic io, input int n,
                            input logic [7:0] d, input string tag);
        logic       h;
        int         off;
        logic [7:0] b;
        h   = hit_m(a, io);
        off = int'(a) - int'(BASE);
        latch(a, io, tag);
        for (int i = 0; i < n; i++) begin
            b = (i == n - 1) ? d : 8'($urandom_range(0, 254));
            drive(0, 0, 8'h00, 1, b, 1, 0, io, !h || i >= WS, 0, 0, 8'h00, tag);
        end
        drive(0, 0, 8'h00, 0, 8'h00, 1, 1, io, 1, 0, 0, 8'h00, tag);
        if (h) mem_m[off] = d;
    endtask

    task automatic both_low(input logic [15:0] a, input logic io, input string tag);
        latch(a, io, tag);
        drive(0, 0, 8'h00, 0, 8'h00, 0, 0, io, 1, 1, 0, 8'h00, tag);
        idle(tag);
    endtask

    task automatic early_rel(input logic [15:0] a, input int k, input string tag);
        latch(a, 0, tag);
        for (int i = 0; i < k; i++)
            drive(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, tag);
        drive(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00, tag);
        idle(tag);
    endtask

    // Runs a hit access up to its first ACCESS cycle, then ends it by flip or reset.
    task automatic to_access(input logic [15:0] a, input logic wr, input string tag);
        int         off;
        logic [7:0] dv;
        off = int'(a) - int'(BASE);
        dv  = mem_m[off];
        latch(a, 0, tag);
        for (int i = 0; i <= WS; i++) begin
            if (wr)
                drive(0, 0, 8'h00, 1, 8'($urandom_range(0, 254)), 1, 0, 0,
                      i >= WS, 0, 0, 8'h00, tag);
            else
                drive(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, i >= WS, 0, i >= WS, dv, tag);
        end
    endtask

    task automatic flip(input logic [15:0] a, input logic wr, input string tag);
        to_access(a, wr, tag);
        drive(0, 0, 8'h00, 0, 8'h00, !wr, wr, 0, 1, 1, 0, 8'h00, tag);
        idle(tag);
    endtask

    task automatic reset_access(input logic [15:0] a, input logic wr, input string tag);
        to_access(a, wr, tag);
        sel_m = 1'b0;
        drive(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, tag);
        idle(tag);
    endtask

    task automatic abort_write(input logic [15:0] a, input int m,
                               input logic [15:0] b, input string tag);
        logic h;
        h = hit_m(a, 0);
        latch(a, 0, tag);
        for (int i = 0; i < m; i++)
            drive(0, 0, 8'h00, 1, 8'($urandom_range(0, 254)), 1, 0, 0,
                  !h || i >= WS, 0, 0, 8'h00, tag);
        latch(b, 0, tag);
        rd_strobe(b, 0, WS + 2, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.ale     = 1'b0;
        bus.addr_hi = 8'h00;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.io_m    = 1'b0;
        tb_oe       = 1'b0;
        tb_d        = 8'h00;
        sel_m       = 1'b0;

        drive(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, "reset");
        drive(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, "reset");
        idle("reset_idle");

        for (int i = 0; i < DEPTH; i++)
            do_write(BASE + 16'(i), 0, WS + 2, 8'($urandom_range(0, 254)), "preload");

        do_write(16'h0105, 0, 3, 8'h3C, "write_ws");
        do_read(16'h0105, 0, 2, "readback");
        do_read(16'h00FF, 0, 2, "bound_00FF");
        do_read(16'h0100, 0, 2, "bound_0100");
        do_read(16'h01FF, 0, 2, "bound_01FF");
        do_read(16'h0200, 0, 2, "bound_0200");
        do_read(16'h0110, 1, 2, "io_cycle");
        both_low(16'h0120, 0, "both_low");
        early_rel(16'h0130, 1, "early_rel");
        abort_write(16'h0107, 3, 16'h0107, "abort_107");
        reset_access(16'h0105, 0, "rst_read");
        do_read(16'h0105, 0, 2, "after_rst");
        reset_access(16'h0140, 1, "rst_write");
        do_read(16'h0140, 0, 2, "after_rst_wr");
        flip(16'h0150, 0, "flip_rd");
        flip(16'h0151, 1, "flip_wr");
        do_read(16'h0151, 0, 2, "after_flip");

        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        io;
            int          k;
            a  = 16'h00F8 + 16'($urandom_range(0, 'h118));
            b  = BASE + 16'($urandom_range(0, DEPTH - 1));
            io = ($urandom_range(0, 7) == 0);
            k  = int'($urandom_range(0, 10));
            case (k)
                0, 1, 2: do_read(a, io, int'($urandom_range(WS + 1, WS + 3)), "rnd_rd");
                3, 4: do_write(a, io, int'($urandom_range(WS + 2, WS + 4)),
                               8'($urandom_range(0, 254)), "rnd_wr");
                5: both_low(a, io, "rnd_both");
                6: early_rel(b, int'($urandom_range(1, WS)), "rnd_early");
                7: abort_write(b, int'($urandom_range(1, WS + 2)), a, "rnd_abort");
                8: flip(b, $urandom_range(0, 1) == 1, "rnd_flip");
                9: reset_access(b, 1'b0, "rnd_rst_rd");
                default: reset_access(b, 1'b1, "rnd_rst_wr");
            endcase
        end

        for (int i = 0; i < 16; i++)
            do_read(BASE + 16'(i * 16), 0, WS + 1, "final_scan");

        repeat (10) @(negedge phi1);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
